// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Optional signed MULT/DIV support is enabled with `define MULDIV_SIGNED_EN.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DW     = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned STEPS  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_busy;
  logic                r_done;
  logic [DW-1:0]       r_hi;
  logic [DW-1:0]       r_lo;
  logic [2*DW-1:0]     r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [DW-1:0]       r_b;
  logic [DW-1:0]       r_rs;
  logic                r_is_div;
  logic                r_div0;

  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic [DW-1:0]       w_hi_nxt;
  logic [DW-1:0]       w_lo_nxt;
  logic [2*DW-1:0]     w_acc_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_latch;

  logic [DW-1:0]       w_a_mag;
  logic [DW-1:0]       w_b_mag;
  logic [DW:0]         w_mul_sum;
  logic [2*DW-1:0]     w_mul_step;
  logic [DW:0]         w_div_top;
  logic [DW:0]         w_div_diff;
  logic [2*DW-1:0]     w_div_step;
  logic [2*DW-1:0]     w_prod;
  logic [DW-1:0]       w_quo;
  logic [DW-1:0]       w_rem;
  logic [DW-1:0]       w_res_hi;
  logic [DW-1:0]       w_res_lo;

`ifdef MULDIV_SIGNED_EN
  logic                w_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic                r_neg_q;
  logic                r_neg_r;

  // MULT/DIV (op[0]=0) run on magnitudes; result signs are recorded at latch time
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & rs_data[DW-1];
  assign w_b_neg  = w_signed & rt_data[DW-1];
  assign w_a_mag  = w_a_neg ? DW'(-rs_data) : rs_data;
  assign w_b_mag  = w_b_neg ? DW'(-rt_data) : rt_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_latch) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end

  // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000 negates to itself
  always_comb begin
    w_prod = r_neg_q ? (2*DW)'(-r_acc) : r_acc;
    w_quo  = r_neg_q ? DW'(-r_acc[DW-1:0]) : r_acc[DW-1:0];
    w_rem  = r_neg_r ? DW'(-r_acc[2*DW-1:DW]) : r_acc[2*DW-1:DW];
  end
`else
  logic                w_unused_op0;

  assign w_unused_op0 = op[0];
  assign w_a_mag      = rs_data;
  assign w_b_mag      = rt_data;
  assign w_prod       = r_acc;
  assign w_quo        = r_acc[DW-1:0];
  assign w_rem        = r_acc[2*DW-1:DW];
`endif

  // Shift-add multiply step: multiplier consumed from acc LSB, product grows from top
  assign w_mul_sum  = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_b} : (DW+1)'(0));
  assign w_mul_step = {w_mul_sum, r_acc[DW-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient}
  assign w_div_top  = r_acc[2*DW-1:DW-1];
  assign w_div_diff = w_div_top - {1'b0, r_b};
  assign w_div_step = w_div_diff[DW] ? {r_acc[2*DW-2:0], 1'b0}
                                     : {w_div_diff[DW-1:0], r_acc[DW-2:0], 1'b1};

  always_comb begin
    w_res_hi = w_prod[2*DW-1:DW];
    w_res_lo = w_prod[DW-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_res_hi = r_rs;
        w_res_lo = {DW{1'b1}};
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch     = 1'b1;
          w_state_nxt = S_RUN;
          w_busy_nxt  = 1'b1;
        end else begin
          if (hi_we) w_hi_nxt = wdata;
          if (lo_we) w_lo_nxt = wdata;
        end
      end
      S_RUN: begin
        w_acc_nxt = r_is_div ? w_div_step : w_mul_step;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(STEPS - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_hi_nxt    = w_res_hi;
        w_lo_nxt    = w_res_lo;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
        if (start) begin
          w_latch     = 1'b1;
          w_state_nxt = S_RUN;
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
    if (w_latch) begin
      w_acc_nxt = {DW'(0), w_a_mag};
      w_cnt_nxt = CNT_W'(0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_b      <= '0;
      r_rs     <= '0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
      r_acc  <= w_acc_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_latch) begin
        r_b      <= w_b_mag;
        r_rs     <= rs_data;
        r_is_div <= op[1];
        r_div0   <= (rt_data == DW'(0));
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (signed or unsigned build).
module tb_muldiv_unit;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  muldiv_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch one op and wait for done; reports latency (0 on timeout) and whether hi/lo held
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int lat, output bit held);
    logic [31:0] ph;
    logic [31:0] pl;
    ph = hi;
    pl = lo;
    held = 1'b1;
    op = o;
    rs_data = a;
    rt_data = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
      if (hi !== ph || lo !== pl) held = 1'b0;
    end
    rh = hi;
    rl = lo;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    #2 reset_n = 1'b1;
    tick();
    checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL reset_hi: got %h exp %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL reset_lo: got %h exp %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
  endtask

  task automatic test_multu();
    logic [31:0] rh, rl;
    int lat;
    bit held;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, lat, held);
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d exp 33", lat); end
    checks++; if (rh !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h exp %h", rh, 32'hFFFFFFFE); end
    checks++; if (rl !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h exp %h", rl, 32'h1); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL multu_hold: got %b exp 1", held); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b exp 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b exp 0", done); end
  endtask

  task automatic test_divu_ignored_start();
    int lat;
    bit held;
    bit extra;
    held = 1'b1;
    lat = 0;
    op = OP_DIVU; rs_data = 32'd20; rt_data = 32'd8; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divu_busy: got %b exp 1", busy); end
    for (int n = 1; n <= 40; n++) begin
      if (n == 10) begin
        op = OP_MULTU; rs_data = 32'd100; rt_data = 32'd3; start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) held = 1'b0;
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d exp 33", lat); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL divu_hold: got %b exp 1", held); end
    checks++; if (lo !== 32'd2) begin errors++; $display("FAIL divu_lo: got %h exp %h", lo, 32'd2); end
    checks++; if (hi !== 32'd4) begin errors++; $display("FAIL divu_hi: got %h exp %h", hi, 32'd4); end
    extra = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (busy || done) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL divu_start_not_queued: got %b exp 0", extra); end
  endtask

  task automatic test_signed();
    logic [31:0] rh, rl;
    logic [31:0] e_mh, e_ml, e_dh, e_dl, e_oh, e_ol;
    int lat;
    bit held;
`ifdef MULDIV_SIGNED_EN
    e_mh = 32'hFFFFFFFF; e_ml = 32'hFFFFFFF1;
    e_dh = 32'hFFFFFFFF; e_dl = 32'hFFFFFFFD;
    e_oh = 32'h00000000; e_ol = 32'h80000000;
`else
    e_mh = 32'h00000004; e_ml = 32'hFFFFFFF1;
    e_dh = 32'h00000001; e_dl = 32'h7FFFFFFC;
    e_oh = 32'h80000000; e_ol = 32'h00000000;
`endif
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, rh, rl, lat, held);
    checks++; if (rh !== e_mh) begin errors++; $display("FAIL mult_hi: got %h exp %h", rh, e_mh); end
    checks++; if (rl !== e_ml) begin errors++; $display("FAIL mult_lo: got %h exp %h", rl, e_ml); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, rh, rl, lat, held);
    checks++; if (rl !== e_dl) begin errors++; $display("FAIL div_lo: got %h exp %h", rl, e_dl); end
    checks++; if (rh !== e_dh) begin errors++; $display("FAIL div_hi: got %h exp %h", rh, e_dh); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, rh, rl, lat, held);
    checks++; if (rl !== e_ol) begin errors++; $display("FAIL div_ovf_lo: got %h exp %h", rl, e_ol); end
    checks++; if (rh !== e_oh) begin errors++; $display("FAIL div_ovf_hi: got %h exp %h", rh, e_oh); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_ovf_latency: got %0d exp 33", lat); end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] rh, rl;
    int lat;
    bit held;
    run_op(OP_DIV, 32'd12, 32'd0, rh, rl, lat, held);
    checks++; if (rl !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h exp %h", rl, 32'hFFFFFFFF); end
    checks++; if (rh !== 32'd12) begin errors++; $display("FAIL div0_hi: got %h exp %h", rh, 32'd12); end
    run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, rh, rl, lat, held);
    checks++; if (rl !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_neg_lo: got %h exp %h", rl, 32'hFFFFFFFF); end
    checks++; if (rh !== 32'hFFFFFFFB) begin errors++; $display("FAIL div0_neg_hi: got %h exp %h", rh, 32'hFFFFFFFB); end
    run_op(OP_DIVU, 32'h9ABCDEF0, 32'd0, rh, rl, lat, held);
    checks++; if (rh !== 32'h9ABCDEF0) begin errors++; $display("FAIL divu0_hi: got %h exp %h", rh, 32'h9ABCDEF0); end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] rh, rl;
    int lat;
    bit held;
    wdata = 32'h1234; hi_we = 1'b1;
    tick();
    hi_we = 1'b0;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi: got %h exp %h", hi, 32'h1234); end
    wdata = 32'h5678; lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo: got %h exp %h", lo, 32'h5678); end
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo_hi_kept: got %h exp %h", hi, 32'h1234); end
    wdata = 32'hCAFEF00D; hi_we = 1'b1; lo_we = 1'b1;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    checks++; if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) begin
      errors++; $display("FAIL mthi_mtlo_both: got %h/%h exp %h", hi, lo, 32'hCAFEF00D);
    end
    // start and MTHI together: start wins
    op = OP_MULTU; rs_data = 32'd2; rt_data = 32'd3; start = 1'b1;
    wdata = 32'hDEAD0000; hi_we = 1'b1;
    tick();
    start = 1'b0; hi_we = 1'b0;
    checks++; if (hi !== 32'hCAFEF00D) begin errors++; $display("FAIL start_wins_hi: got %h exp %h", hi, 32'hCAFEF00D); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_wins_busy: got %b exp 1", busy); end
    wdata = 32'hBEEF0000; hi_we = 1'b1; lo_we = 1'b1;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    checks++; if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) begin
      errors++; $display("FAIL busy_mt_ignored: got %h/%h exp %h", hi, lo, 32'hCAFEF00D);
    end
    lat = 0;
    for (int n = 2; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL mt_op_latency: got %0d exp 33", lat); end
    checks++; if (lo !== 32'd6 || hi !== 32'd0) begin errors++; $display("FAIL mt_op_result: got %h/%h exp %h/%h", hi, lo, 32'd0, 32'd6); end
    rh = 32'h0; rl = 32'h0; held = 1'b0;
    if (rh !== rl || held) $display("unexpected scratch state");
  endtask

  task automatic test_reset_abort();
    logic [31:0] rh, rl;
    int lat;
    bit held;
    bit saw_done;
    wdata = 32'h1234; hi_we = 1'b1;
    tick();
    hi_we = 1'b0;
    op = OP_MULTU; rs_data = 32'd8; rt_data = 32'd12; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 15; n++) tick();
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL abort_hilo: got %h/%h exp 0/0", hi, lo); end
    tick();
    #2 reset_n = 1'b1;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b exp 0", saw_done); end
    run_op(OP_MULTU, 32'd8, 32'd12, rh, rl, lat, held);
    checks++; if (rl !== 32'd96 || rh !== 32'd0) begin errors++; $display("FAIL after_abort: got %h/%h exp %h/%h", rh, rl, 32'd0, 32'd96); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL after_abort_latency: got %0d exp 33", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rh, rl;
    int lat;
    bit held;
    run_op(OP_MULTU, 32'd7, 32'd6, rh, rl, lat, held);
    checks++; if (rl !== 32'd42 || rh !== 32'd0) begin errors++; $display("FAIL b2b_first: got %h/%h exp %h/%h", rh, rl, 32'd0, 32'd42); end
    run_op(OP_DIVU, 32'd100, 32'd7, rh, rl, lat, held);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d exp 33", lat); end
    checks++; if (rl !== 32'd14 || rh !== 32'd2) begin errors++; $display("FAIL b2b_second: got %h/%h exp %h/%h", rh, rl, 32'd2, 32'd14); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %b exp 1", held); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu_ignored_start();
    test_signed();
    test_div_by_zero();
    test_mthi_mtlo();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
